result_frame_reader: RTL and testbench
======================================

Name: result_frame_reader

Overview:
- Responder on the result-memory write interface driven by the threshold block (column/row/data/write-enable).
- Stores each written binarised pixel in an internal frame buffer.
- On a start pulse, streams the full frame back out in raster order over a valid/ready handshake.
- Sits between the threshold stage and the downstream output or verification sink.

Parameters:
- WIDTH_BITS, 8, column address width; frame width = 2**WIDTH_BITS.
- HEIGHT_BITS, 8, row address width; frame height = 2**HEIGHT_BITS.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- iResultCol  input  WIDTH_BITS  write column.
- iResultRow  input  HEIGHT_BITS  write row.
- iResultData  input  8  write pixel value.
- iResultWren  input  1  write enable.
- iStart  input  1  one-cycle pulse; starts readout of the whole frame.
- oPixelCol  output  WIDTH_BITS  column of the current output pixel.
- oPixelRow  output  HEIGHT_BITS  row of the current output pixel.
- oPixelData  output  8  output pixel value.
- oPixelValid  output  1  output pixel is valid.
- iPixelReady  input  1  sink accepts the pixel.
- oPixelLast  output  1  current pixel is the last of the frame (max column, max row).
- oBusy  output  1  readout in progress.
- oDone  output  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE; read counters=0; all outputs=0. Buffer contents are not cleared (undefined after power-up).
- Buffer: 2**(WIDTH_BITS+HEIGHT_BITS) x 8, address = {row, col}. Synchronous write; synchronous read with 1-cycle latency.
- Write port: when iResultWren=1 and FSM=IDLE, store iResultData at {iResultRow, iResultCol} on the clock edge.
  - Writes while oBusy=1 are ignored (the frame is frozen during readout).
  - Same address written twice: last write wins.
- FSM states: IDLE, FETCH, PRESENT, DONE.
  - IDLE: oBusy=0. On iStart=1: counters := (0,0), go to FETCH. iStart together with iResultWren: the write is performed, then readout starts; the written pixel is visible in the stream.
  - FETCH: issue read at current {row, col}; oBusy=1; oPixelValid=0; next state PRESENT.
  - PRESENT: oPixelValid=1; oPixelData = read data; oPixelCol/oPixelRow = counters; oPixelLast = (col==max && row==max).
    - Data, coordinates and Last are held stable while iPixelReady=0.
    - Handshake is valid&ready. On handshake with Last=0: col += 1; on col wrap to 0, row += 1; go to FETCH.
    - On handshake with Last=1: go to DONE.
  - DONE: oDone=1 for exactly one cycle; oPixelValid=0; oBusy=0; next state IDLE.
- Throughput: one pixel per 2 cycles when iPixelReady is held at 1. First oPixelValid appears 2 cycles after the iStart edge.
- iStart while busy or in DONE: ignored.
- Mid-frame reset: immediate return to IDLE, outputs=0. The next iStart restarts at (0,0).
- Counters wrap naturally at their widths; no overflow flag.

Test Plan (WIDTH_BITS=2, HEIGHT_BITS=2, 16 pixels):
1. Write data = 16*row + col to all 16 addresses, pulse iStart, hold iPixelReady=1 -> 16 beats with data 0,1,2,3,16,17,…,51 in raster order. oPixelLast=1 only at (3,3). oDone pulses one cycle after that beat. Total 16*2+1 cycles after the start edge.
2. Same frame, iPixelReady toggling 1,0,0,1,… -> identical sequence, no drops or duplicates. Data and coordinates held stable during stall cycles.
3. During readout, write 255 to (0,0) and pulse iStart again -> stream unaffected. A second readout after oDone shows (0,0)=0, confirming the write was ignored.
4. Write (1,2)=7, then (1,2)=9, then stream -> pixel (col 1, row 2) = 9.
5. Assert reset=0 after 5 handshakes, release, pulse iStart -> all outputs 0 during reset. Stream restarts at (0,0) and runs all 16 beats.
6. iStart in the same cycle as a write of 200 to (0,0) -> first streamed pixel = 200.

Source files
------------

// File: rtl/result_frame_reader.sv
// Result frame reader: captures binarised pixels written by the threshold
// stage into a frame buffer, then streams the whole frame back out in raster
// order over a valid/ready handshake when started.
module result_frame_reader #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH_BITS-1:0]  iResultCol,
    input  logic [HEIGHT_BITS-1:0] iResultRow,
    input  logic [7:0]             iResultData,
    input  logic                   iResultWren,
    input  logic                   iStart,
    output logic [WIDTH_BITS-1:0]  oPixelCol,
    output logic [HEIGHT_BITS-1:0] oPixelRow,
    output logic [7:0]             oPixelData,
    output logic                   oPixelValid,
    input  logic                   iPixelReady,
    output logic                   oPixelLast,
    output logic                   oBusy,
    output logic                   oDone
);

    localparam int AW    = WIDTH_BITS + HEIGHT_BITS;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    state_t                 state;
    logic [WIDTH_BITS-1:0]  col;
    logic [HEIGHT_BITS-1:0] row;
    logic [7:0]             mem [DEPTH];
    logic [AW-1:0]          rd_addr;
    logic                   handshake;

    assign rd_addr   = {row, col};
    assign handshake = oPixelValid & iPixelReady;

    // Frame buffer write port; the frame is frozen outside IDLE so the
    // readout always sees a consistent image.
    always_ff @(posedge clock) begin
        if (state == IDLE && iResultWren)
            mem[{iResultRow, iResultCol}] <= iResultData;
    end

    // Readout FSM: FETCH issues the buffer read, PRESENT holds the pixel
    // until the sink takes it, DONE emits the end-of-frame pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            oPixelCol   <= '0;
            oPixelRow   <= '0;
            oPixelData  <= '0;
            oPixelValid <= 1'b0;
            oPixelLast  <= 1'b0;
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        col   <= '0;
                        row   <= '0;
                        oBusy <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    // Synchronous read: data lands together with valid.
                    oPixelData  <= mem[rd_addr];
                    oPixelCol   <= col;
                    oPixelRow   <= row;
                    oPixelLast  <= (&col) && (&row);
                    oPixelValid <= 1'b1;
                    state       <= PRESENT;
                end
                PRESENT: begin
                    if (handshake) begin
                        oPixelValid <= 1'b0;
                        if (oPixelLast) begin
                            oBusy <= 1'b0;
                            oDone <= 1'b1;
                            state <= DONE;
                        end else begin
                            col <= col + WIDTH_BITS'(1);
                            if (&col)
                                row <= row + HEIGHT_BITS'(1);
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    oDone <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_frame_reader.sv
// Self-checking bench for result_frame_reader on a 4x4 frame.
module tb_result_frame_reader;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] iResultCol = '0;
    logic [1:0] iResultRow = '0;
    logic [7:0] iResultData = '0;
    logic       iResultWren = 1'b0;
    logic       iStart = 1'b0;
    logic [1:0] oPixelCol;
    logic [1:0] oPixelRow;
    logic [7:0] oPixelData;
    logic       oPixelValid;
    logic       iPixelReady = 1'b0;
    logic       oPixelLast;
    logic       oBusy;
    logic       oDone;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] model [16];

    typedef struct {
        logic [1:0] col;
        logic [1:0] row;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [16];

    result_frame_reader #(.WIDTH_BITS(2), .HEIGHT_BITS(2)) dut (
        .clock(clock), .reset(reset),
        .iResultCol(iResultCol), .iResultRow(iResultRow),
        .iResultData(iResultData), .iResultWren(iResultWren),
        .iStart(iStart),
        .oPixelCol(oPixelCol), .oPixelRow(oPixelRow), .oPixelData(oPixelData),
        .oPixelValid(oPixelValid), .iPixelReady(iPixelReady),
        .oPixelLast(oPixelLast), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_px(input logic [1:0] c, input logic [1:0] r, input logic [7:0] d);
        iResultCol = c; iResultRow = r; iResultData = d; iResultWren = 1'b1;
        tick();
        iResultWren = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return {18'd0, oPixelCol, oPixelRow, oPixelData, oPixelValid, oPixelLast, oBusy, oDone};
    endfunction

    // mode 0: ready always 1; mode 1: ready pattern 1,0,0,1 on valid cycles.
    // intrude: write 255 to (0,0) and re-pulse iStart mid-stream.
    // start_wr: write 200 to (0,0) in the iStart cycle.
    task automatic run_stream(input string tag, input int mode, input bit intrude, input bit start_wr);
        int  cyc, beats, vcnt;
        bit  done_seen;
        logic r;
        logic [31:0] exp_v;
        if (start_wr) begin
            iResultCol = 2'd0; iResultRow = 2'd0; iResultData = 8'd200; iResultWren = 1'b1;
            model[0] = 8'd200;
        end
        iStart = 1'b1;
        tick();
        iStart = 1'b0; iResultWren = 1'b0;
        cyc = 0; beats = 0; vcnt = 0; done_seen = 1'b0;
        chk({tag, "_fetch_first"}, {oPixelValid, oBusy}, 2'b01);
        while (cyc < 300 && !done_seen) begin
            if (intrude && cyc == 5) begin
                iResultCol = 2'd0; iResultRow = 2'd0; iResultData = 8'd255;
                iResultWren = 1'b1; iStart = 1'b1;
            end else begin
                iResultWren = 1'b0; iStart = 1'b0;
            end
            if (oDone) begin
                done_seen = 1'b1;
                chk({tag, "_beats"}, beats, 16);
                chk({tag, "_done_state"}, {oPixelValid, oBusy}, 2'b00);
                if (mode == 0) chk({tag, "_done_cycle"}, cyc, 32);
            end else if (oPixelValid) begin
                exp_v = {16'd0, 2'(beats % 4), 2'(beats / 4), model[beats], 1'b1, 1'b1, (beats == 15) ? 1'b1 : 1'b0, 1'b0};
                chk({tag, "_beat"}, {16'd0, oPixelCol, oPixelRow, oPixelData, oPixelValid, oBusy, oPixelLast, oDone}, exp_v);
                r = (mode == 0) ? 1'b1 : ((vcnt % 4 == 0) || (vcnt % 4 == 3));
                vcnt++;
                iPixelReady = r;
                if (r) beats++;
            end else begin
                iPixelReady = 1'b0;
            end
            tick();
            cyc++;
        end
        iResultWren = 1'b0; iStart = 1'b0; iPixelReady = 1'b0;
        if (!done_seen) chk({tag, "_timeout"}, 0, 1);
        chk({tag, "_done_pulse_end"}, {oDone, oBusy, oPixelValid}, 3'b000);
    endtask

    initial begin
        int hs, guard;
        // Write table for the raster test frame: value = 16*row + col.
        vecs[0]  = '{2'd0, 2'd0, 8'd0,  8'd0};
        vecs[1]  = '{2'd1, 2'd0, 8'd1,  8'd1};
        vecs[2]  = '{2'd2, 2'd0, 8'd2,  8'd2};
        vecs[3]  = '{2'd3, 2'd0, 8'd3,  8'd3};
        vecs[4]  = '{2'd0, 2'd1, 8'd16, 8'd16};
        vecs[5]  = '{2'd1, 2'd1, 8'd17, 8'd17};
        vecs[6]  = '{2'd2, 2'd1, 8'd18, 8'd18};
        vecs[7]  = '{2'd3, 2'd1, 8'd19, 8'd19};
        vecs[8]  = '{2'd0, 2'd2, 8'd32, 8'd32};
        vecs[9]  = '{2'd1, 2'd2, 8'd33, 8'd33};
        vecs[10] = '{2'd2, 2'd2, 8'd34, 8'd34};
        vecs[11] = '{2'd3, 2'd2, 8'd35, 8'd35};
        vecs[12] = '{2'd0, 2'd3, 8'd48, 8'd48};
        vecs[13] = '{2'd1, 2'd3, 8'd49, 8'd49};
        vecs[14] = '{2'd2, 2'd3, 8'd50, 8'd50};
        vecs[15] = '{2'd3, 2'd3, 8'd51, 8'd51};

        #12;
        chk("reset_outputs", all_outs(), 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_after_reset", all_outs(), 32'd0);

        // 1. Write frame (reverse order to exercise addressing), stream at full rate.
        for (int i = 15; i >= 0; i--) begin
            write_px(vecs[i].col, vecs[i].row, vecs[i].data);
            model[i] = vecs[i].exp;
        end
        run_stream("full_rate", 0, 1'b0, 1'b0);

        // 2. Same frame with a stalling sink.
        run_stream("stalled", 1, 1'b0, 1'b0);

        // 3. Write and iStart during readout are ignored; re-read confirms.
        run_stream("intrude", 0, 1'b1, 1'b0);
        run_stream("after_intrude", 0, 1'b0, 1'b0);

        // 4. Last write wins at (col 1, row 2).
        write_px(2'd1, 2'd2, 8'd7);
        write_px(2'd1, 2'd2, 8'd9);
        model[9] = 8'd9;
        run_stream("overwrite", 0, 1'b0, 1'b0);

        // 5. Mid-frame reset after 5 handshakes, then a full restart.
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        iPixelReady = 1'b1;
        hs = 0; guard = 0;
        while (hs < 5 && guard < 50) begin
            if (oPixelValid) hs++;
            tick();
            guard++;
        end
        if (hs < 5) chk("reset_mid_timeout", hs, 5);
        iPixelReady = 1'b0;
        reset = 1'b0;
        #1;
        chk("reset_mid_outputs", all_outs(), 32'd0);
        tick();
        chk("reset_mid_held", all_outs(), 32'd0);
        reset = 1'b1;
        tick();
        run_stream("after_reset", 0, 1'b0, 1'b0);

        // 6. Write coinciding with iStart is visible as the first pixel.
        run_stream("start_write", 0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
